// File: rtl/fast_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fast_pkg : shared types and circle geometry for the FAST corner detector
// Revision : 1.0
// ---------------------------------------------------------------------------
package fast_pkg;

  localparam int NUM_POINTS = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    EVAL  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Bresenham circle of radius 3, clockwise from straight up
  localparam logic signed [2:0] CIRCLE_DX [NUM_POINTS] = '{
    3'sd0,  3'sd1,  3'sd2,  3'sd3,  3'sd3,  3'sd3,  3'sd2,  3'sd1,
    3'sd0, -3'sd1, -3'sd2, -3'sd3, -3'sd3, -3'sd3, -3'sd2, -3'sd1
  };
  localparam logic signed [2:0] CIRCLE_DY [NUM_POINTS] = '{
   -3'sd3, -3'sd3, -3'sd2, -3'sd1,  3'sd0,  3'sd1,  3'sd2,  3'sd3,
    3'sd3,  3'sd3,  3'sd2,  3'sd1,  3'sd0, -3'sd1, -3'sd2, -3'sd3
  };

endpackage
`default_nettype wire

// File: rtl/fast_corner_detect_arc_check.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fast_arc_check : flags a circular run of ARC_LEN set bits in a 16-bit mask
// Revision       : 1.0
// ---------------------------------------------------------------------------
module fast_arc_check
  import fast_pkg::*;
#(
  parameter int ARC_LEN = 9
) (
  input  logic [NUM_POINTS-1:0] mask,
  output logic                  hit
);

  logic [2*NUM_POINTS-1:0] w_dbl;
  logic                    w_run;

  // doubling the mask turns the wrap from point 15 to point 0 into a straight run
  assign w_dbl = {mask, mask};

  always_comb begin
    hit   = 1'b0;
    w_run = 1'b0;
    for (int s = 0; s < NUM_POINTS; s++) begin
      w_run = 1'b1;
      for (int k = 0; k < ARC_LEN; k++) begin
        w_run = w_run & w_dbl[s+k];
      end
      hit = hit | w_run;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fast_corner_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fast_corner_detect : raster-scan FAST segment-test corner detector
// Revision           : 1.0
// ---------------------------------------------------------------------------
module fast_corner_detect
  import fast_pkg::*;
#(
  parameter int X_MAX       = 200,
  parameter int Y_MAX       = 200,
  parameter int PIXEL_DEPTH = 8,
  parameter int ARC_LEN     = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     new_trans,
  input  logic [$clog2(X_MAX)-1:0] max_x,
  input  logic [$clog2(Y_MAX)-1:0] max_y,
  input  logic [PIXEL_DEPTH-1:0]   threshold,
  output logic [$clog2(X_MAX):0]   x_addr_img,
  output logic [$clog2(Y_MAX):0]   y_addr_img,
  output logic                     ren_img,
  input  logic [PIXEL_DEPTH-1:0]   rdat_img,
  output logic                     corner_valid,
  output logic [$clog2(X_MAX)-1:0] corner_x,
  output logic [$clog2(Y_MAX)-1:0] corner_y,
  output logic                     busy,
  output logic                     scan_done
);

  localparam int XW = $clog2(X_MAX);
  localparam int YW = $clog2(Y_MAX);
  localparam int PW = PIXEL_DEPTH;

  state_t r_state, w_next;

  logic [XW-1:0]   r_max_x, r_cx;
  logic [YW-1:0]   r_max_y, r_cy;
  logic [PW-1:0]   r_thr, r_center;
  logic [4:0]      r_idx, r_rd_idx;
  logic            r_rd_vld;
  logic [NUM_POINTS-1:0] r_bright, r_dark;

  logic            w_params_ok, w_last_x, w_last_y, w_hit_b, w_hit_d;
  logic [3:0]      w_cidx, w_rd_pt;
  logic signed [2:0] w_dx, w_dy;
  logic [XW:0]     w_ax;
  logic [YW:0]     w_ay;
  logic [PW:0]     w_pix, w_cen, w_thr;
  logic            w_pt_bright, w_pt_dark;

  assign w_params_ok = (max_x >= XW'(6)) && (max_y >= YW'(6));
  assign w_last_x    = (r_cx == r_max_x - XW'(3));
  assign w_last_y    = (r_cy == r_max_y - YW'(3));

  // read index 0 is the centre; indices 1..16 map to circle points 0..15
  assign w_cidx = r_idx[3:0] - 4'd1;
  assign w_dx   = (r_idx == 5'd0) ? 3'sd0 : CIRCLE_DX[w_cidx];
  assign w_dy   = (r_idx == 5'd0) ? 3'sd0 : CIRCLE_DY[w_cidx];
  assign w_ax   = {1'b0, r_cx} + {{(XW-2){w_dx[2]}}, w_dx};
  assign w_ay   = {1'b0, r_cy} + {{(YW-2){w_dy[2]}}, w_dy};

  assign ren_img    = (r_state == READ);
  assign x_addr_img = ren_img ? w_ax : '0;
  assign y_addr_img = ren_img ? w_ay : '0;
  assign busy       = (r_state == READ) || (r_state == DRAIN) || (r_state == EVAL);
  assign scan_done  = (r_state == DONE);

  assign w_pix       = {1'b0, rdat_img};
  assign w_cen       = {1'b0, r_center};
  assign w_thr       = {1'b0, r_thr};
  assign w_pt_bright = w_pix > (w_cen + w_thr);
  assign w_pt_dark   = (w_pix + w_thr) < w_cen;
  assign w_rd_pt     = r_rd_idx[3:0] - 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (new_trans) begin
      w_next = w_params_ok ? READ : DONE;
    end else begin
      case (r_state)
        IDLE:    w_next = IDLE;
        READ:    if (r_idx == 5'd16) w_next = DRAIN;
        DRAIN:   w_next = EVAL;
        EVAL:    w_next = (w_last_x && w_last_y) ? DONE : READ;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max_x      <= '0;
      r_max_y      <= '0;
      r_thr        <= '0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_idx        <= '0;
      r_rd_idx     <= '0;
      r_rd_vld     <= 1'b0;
      r_center     <= '0;
      r_bright     <= '0;
      r_dark       <= '0;
      corner_valid <= 1'b0;
      corner_x     <= '0;
      corner_y     <= '0;
    end else begin
      r_rd_vld     <= ren_img;
      r_rd_idx     <= r_idx;
      corner_valid <= 1'b0;
      if (new_trans) begin
        r_max_x <= max_x;
        r_max_y <= max_y;
        r_thr   <= threshold;
        r_cx    <= XW'(3);
        r_cy    <= YW'(3);
        r_idx   <= '0;
      end else if (r_state == READ) begin
        r_idx <= (r_idx == 5'd16) ? 5'd0 : r_idx + 5'd1;
      end else if (r_state == EVAL) begin
        corner_valid <= w_hit_b | w_hit_d;
        if (w_hit_b | w_hit_d) begin
          corner_x <= r_cx;
          corner_y <= r_cy;
        end
        if (w_last_x) begin
          r_cx <= XW'(3);
          r_cy <= r_cy + YW'(1);
        end else begin
          r_cx <= r_cx + XW'(1);
        end
      end
      // the centre arrives first, so circle points are classified on arrival
      if (r_rd_vld) begin
        if (r_rd_idx == 5'd0) begin
          r_center <= rdat_img;
        end else begin
          r_bright[w_rd_pt] <= w_pt_bright;
          r_dark[w_rd_pt]   <= w_pt_dark;
        end
      end
    end
  end

  fast_arc_check #(.ARC_LEN(ARC_LEN)) u_arc_bright (.mask(r_bright), .hit(w_hit_b));
  fast_arc_check #(.ARC_LEN(ARC_LEN)) u_arc_dark   (.mask(r_dark),   .hit(w_hit_d));

endmodule
`default_nettype wire

// File: tb/tb_fast_corner_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fast_corner_detect : self-checking bench with a behavioural FAST model
// Revision              : 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fast_corner_detect;

  localparam int ARC = 9;

  logic       clk = 1'b0;
  logic       rst, new_trans;
  logic [7:0] max_x, max_y, threshold;
  logic [8:0] x_addr_img, y_addr_img;
  logic       ren_img;
  logic [7:0] rdat_img;
  logic       corner_valid;
  logic [7:0] corner_x, corner_y;
  logic       busy, scan_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] img [0:255][0:255];
  int exp_x[$], exp_y[$], exp_k[$];

  int DX[16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  int DY[16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  fast_corner_detect #(
    .X_MAX(200), .Y_MAX(200), .PIXEL_DEPTH(8), .ARC_LEN(ARC)
  ) dut (
    .clk(clk), .rst(rst), .new_trans(new_trans),
    .max_x(max_x), .max_y(max_y), .threshold(threshold),
    .x_addr_img(x_addr_img), .y_addr_img(y_addr_img),
    .ren_img(ren_img), .rdat_img(rdat_img),
    .corner_valid(corner_valid), .corner_x(corner_x), .corner_y(corner_y),
    .busy(busy), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  // synchronous SRAM: data one cycle after the read enable
  always @(posedge clk) begin
    if (rst)          rdat_img <= 8'd0;
    else if (ren_img) rdat_img <= img[x_addr_img[7:0]][y_addr_img[7:0]];
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input int v);
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 32; y++)
        img[x][y] = v[7:0];
  endtask

  function automatic int max_run(input bit [15:0] m);
    int best = 0;
    int run  = 0;
    if (m == 16'hFFFF) return 16;
    for (int i = 0; i < 32; i++) begin
      if (m[i % 16]) begin
        run++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
    end
    return best;
  endfunction

  task automatic model_scan(input int mx, input int my, input int t);
    int k;
    exp_x.delete(); exp_y.delete(); exp_k.delete();
    k = 0;
    if (mx < 6 || my < 6) return;
    for (int y = 3; y <= my - 3; y++) begin
      for (int x = 3; x <= mx - 3; x++) begin
        int c, p;
        bit [15:0] b, d;
        c = img[x][y];
        for (int i = 0; i < 16; i++) begin
          p = img[x + DX[i]][y + DY[i]];
          b[i] = (p > c + t);
          d[i] = (p + t < c);
        end
        if (max_run(b) >= ARC || max_run(d) >= ARC) begin
          exp_x.push_back(x); exp_y.push_back(y); exp_k.push_back(k);
        end
        k++;
      end
    end
  endtask

  task automatic run_scan(input int mx, input int my, input int t, input string tag);
    int ncand, exp_done, cycles, rens, k;
    bit done_seen;
    model_scan(mx, my, t);
    ncand    = (mx >= 6 && my >= 6) ? (mx - 5) * (my - 5) : 0;
    exp_done = ncand * 19 + 1;
    max_x = mx[7:0]; max_y = my[7:0]; threshold = t[7:0];
    new_trans = 1'b1;
    @(negedge clk);
    new_trans = 1'b0;
    cycles = 1; rens = 0; done_seen = 0;
    while (!done_seen && cycles <= exp_done + 40) begin
      if (corner_valid) begin
        if (exp_x.size() == 0) begin
          chk({tag, "_extra_corner"}, 1, 0);
        end else begin
          k = exp_k.pop_front();
          chk({tag, "_corner_x"}, corner_x, exp_x.pop_front());
          chk({tag, "_corner_y"}, corner_y, exp_y.pop_front());
          chk({tag, "_corner_cycle"}, cycles, 19 * (k + 1) + 1);
        end
      end
      if (ren_img) begin
        rens++;
        if (x_addr_img > mx[8:0] || y_addr_img > my[8:0])
          chk({tag, "_addr_in_range"}, 0, 1);
      end
      if (scan_done) begin
        done_seen = 1;
        chk({tag, "_done_cycle"}, cycles, exp_done);
        chk({tag, "_busy_at_done"}, busy, 0);
      end else begin
        @(negedge clk);
        cycles++;
      end
    end
    chk({tag, "_done_seen"}, done_seen, 1);
    chk({tag, "_missing_corners"}, exp_x.size(), 0);
    chk({tag, "_read_count"}, rens, ncand * 17);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, scan_done, 0);
  endtask

  initial begin
    int mx, my;
    rst = 1'b1; new_trans = 1'b0;
    max_x = 8'd0; max_y = 8'd0; threshold = 8'd0;
    fill(0);
    repeat (3) @(negedge clk);
    chk("reset_corner_valid", corner_valid, 0);
    chk("reset_corner_x", corner_x, 0);
    chk("reset_corner_y", corner_y, 0);
    chk("reset_busy", busy, 0);
    chk("reset_scan_done", scan_done, 0);
    chk("reset_ren", ren_img, 0);
    rst = 1'b0;
    @(negedge clk);

    fill(100);
    run_scan(19, 19, 10, "flat");

    fill(50); img[10][10] = 8'd200;
    run_scan(19, 19, 20, "single");

    fill(100);
    foreach (DX[i]) if (i >= 12 || i <= 4) img[10 + DX[i]][10 + DY[i]] = 8'd150;
    run_scan(19, 19, 20, "wrap9");

    fill(100);
    foreach (DX[i]) if (i >= 12 || i <= 3) img[10 + DX[i]][10 + DY[i]] = 8'd150;
    run_scan(19, 19, 20, "wrap8");

    fill(100);
    foreach (DX[i]) img[10 + DX[i]][10 + DY[i]] = 8'd120;
    run_scan(19, 19, 20, "equal");

    run_scan(5, 19, 20, "small");

    // abort during the EVAL of a corner candidate
    fill(50); img[3][3] = 8'd200;
    max_x = 8'd19; max_y = 8'd19; threshold = 8'd20; new_trans = 1'b1;
    @(negedge clk);
    new_trans = 1'b0;
    repeat (18) begin
      chk("abort_no_early_corner", corner_valid, 0);
      @(negedge clk);
    end
    chk("abort_busy", busy, 1);
    run_scan(19, 19, 20, "abort_eval");

    // abort in the middle of a READ phase
    fill(50); img[10][10] = 8'd200;
    max_x = 8'd19; max_y = 8'd19; threshold = 8'd20; new_trans = 1'b1;
    @(negedge clk);
    new_trans = 1'b0;
    repeat (7) @(negedge clk);
    run_scan(19, 19, 20, "abort_read");

    // reset mid-scan halts everything until the next start
    max_x = 8'd19; max_y = 8'd19; threshold = 8'd20; new_trans = 1'b1;
    @(negedge clk);
    new_trans = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async_busy", busy, 0);
    chk("rst_async_ren", ren_img, 0);
    chk("rst_async_corner_x", corner_x, 0);
    chk("rst_async_corner_y", corner_y, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 2200; c++) begin
      if (corner_valid || scan_done || busy) chk("rst_halted", 1, 0);
      @(negedge clk);
    end
    chk("rst_still_idle", busy, 0);
    run_scan(19, 19, 20, "after_rst");

    for (int r = 0; r < 3; r++) begin
      mx = $urandom_range(6, 14);
      my = $urandom_range(6, 14);
      for (int x = 0; x <= mx; x++)
        for (int y = 0; y <= my; y++)
          img[x][y] = 8'($urandom_range(0, 255));
      run_scan(mx, my, $urandom_range(0, 40), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
